// File: rtl/diff_link_scheduler_pkg.sv
// Shared types and default parameters for the differential-link frame scheduler.
package diff_link_scheduler_pkg;

    localparam int unsigned DefNumReq = 4;
    localparam int unsigned DefWordW  = 8;
    localparam logic [31:0] DefIncr   = 32'd171;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

endpackage

// File: rtl/diff_link_strobe.sv
// Free-running phase accumulator; strobe marks the cycle after each 32-bit wrap.
module diff_link_strobe
    import diff_link_scheduler_pkg::*;
#(
    parameter logic [31:0] INCR = DefIncr
) (
    input  logic clock,
    input  logic reset_n,
    output logic strobe
);

    logic [31:0] r_acc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= INCR;
        end else begin
            r_acc <= r_acc + INCR;
        end
    end

    // Accumulator below INCR means the last add wrapped; INCR=0 never strobes.
    assign strobe = (r_acc < INCR);

endmodule

// File: rtl/diff_link_scheduler.sv
// Round-robin arbiter feeding one serial line: start bit 1, WORD_W data bits MSB-first, stop bit 0.
module diff_link_scheduler
    import diff_link_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned WORD_W  = DefWordW,
    parameter logic [31:0] INCR    = DefIncr,
    localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*WORD_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      data_signal,
    output logic [IdW-1:0]            active_id,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int unsigned     CntW    = $clog2(WORD_W + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WORD_W - 1);

    logic                w_strobe;
    logic [WORD_W-1:0]   w_words [NUM_REQ];
    logic [IdW-1:0]      w_idx;
    logic [IdW-1:0]      w_win;
    logic                w_found;
    logic                w_grant;
    logic                w_dsig_d;
    state_e              w_state_d;
    logic [WORD_W-1:0]   w_shift_d;
    logic [CntW-1:0]     w_cnt_d;

    state_e              r_state;
    logic [WORD_W-1:0]   r_shift;
    logic [CntW-1:0]     r_cnt;
    logic [IdW-1:0]      r_ptr;
    logic [IdW-1:0]      r_active;
    logic [NUM_REQ-1:0]  r_ready;
    logic                r_dsig;
    logic                r_done;

    diff_link_strobe #(
        .INCR(INCR)
    ) u_strobe (
        .clock  (clock),
        .reset_n(reset_n),
        .strobe (w_strobe)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_words[g] = req_data[g*WORD_W +: WORD_W];
    end

    // Round-robin search starting at r_ptr (one past the last grantee).
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = IdW'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_grant   = 1'b0;
        w_shift_d = r_shift;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_strobe && w_found) begin
                    w_state_d = StStart;
                    w_grant   = 1'b1;
                    w_shift_d = w_words[w_win];
                    w_cnt_d   = '0;
                end
            end
            StStart: begin
                if (w_strobe) w_state_d = StData;
            end
            StData: begin
                if (w_strobe) begin
                    if (r_cnt == LastBit) begin
                        w_state_d = StStop;
                    end else begin
                        w_shift_d = {r_shift[WORD_W-2:0], 1'b0};
                        w_cnt_d   = r_cnt + 1'b1;
                    end
                end
            end
            StStop: begin
                if (w_strobe) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
        // Line value is computed from next state so the registered output tracks the FSM.
        w_dsig_d = (w_state_d == StStart) || ((w_state_d == StData) && w_shift_d[WORD_W-1]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= StIdle;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_active <= '0;
            r_ready  <= '0;
            r_dsig   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_shift <= w_shift_d;
            r_cnt   <= w_cnt_d;
            r_dsig  <= w_dsig_d;
            r_ready <= w_grant ? (NUM_REQ'(1) << w_win) : '0;
            r_done  <= (r_state == StStop) && w_strobe;
            if (w_grant) begin
                r_active <= w_win;
                r_ptr    <= (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
            end
        end
    end

    assign req_ready   = r_ready;
    assign data_signal = r_dsig;
    assign active_id   = r_active;
    assign busy        = (r_state != StIdle);
    assign frame_done  = r_done;

endmodule
